// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the hex-display PIO arbiter.
// Optional host pre-emption is selected with the ARB_HOST_PREEMPT_EN macro in the top.
package pio_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_HOLD = 1'b1;

    localparam int unsigned NUM_REQ_MIN = 2;
    localparam int unsigned NUM_REQ_MAX = 4;

    function automatic int unsigned owner_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pio_rr_picker.sv
// Combinational round-robin picker: first valid requester scanning upward from ptr with wrap.
module pio_rr_picker #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned cand;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = (32'(ptr) + 32'(k)) % NUM_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_display_arbiter.sv
// Round-robin arbiter with minimum ownership hold for the 32-bit hexport display.
// Define ARB_HOST_PREEMPT_EN to let requester 0 take over the display during another owner's hold.
module pio_display_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           disp_out,
    output logic [$clog2(NUM_REQ)-1:0]  owner_id,
    output logic                        owner_valid
);

    localparam int unsigned OW = owner_w(NUM_REQ);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("pio_display_arbiter: NUM_REQ out of range");
    end

    arb_state_t          state_q;
    logic [OW-1:0]       rr_q;
    logic [OW-1:0]       owner_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   disp_q;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [OW-1:0]       pick_idx;
    logic                pick_any;
    logic                preempt;
    logic                xfer;
    logic [OW-1:0]       xfer_idx;
    logic [DATA_W-1:0]   sel_data;

    pio_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef ARB_HOST_PREEMPT_EN
    assign preempt = (state_q == ARB_HOLD) && (owner_q != '0) && req_valid[0] && !reset;
`else
    assign preempt = 1'b0;
`endif

    // Reset gates ready so no handshake can complete while state is being cleared.
    always_comb begin
        req_ready = '0;
        if (!reset) begin
            if (state_q == ARB_IDLE) begin
                req_ready = pick_any ? pick_gnt : '0;
            end else if (preempt) begin
                req_ready[0] = 1'b1;
            end else if (cnt_q != '0) begin
                req_ready[owner_q] = 1'b1;
            end
        end
    end

    always_comb begin
        xfer     = |(req_valid & req_ready);
        xfer_idx = owner_q;
        if (state_q == ARB_IDLE) begin
            xfer_idx = pick_idx;
        end else if (preempt) begin
            xfer_idx = '0;
        end
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (xfer_idx == OW'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (xfer) begin
                disp_q  <= sel_data;
                owner_q <= xfer_idx;
                rr_q    <= OW'((32'(xfer_idx) + 32'd1) % NUM_REQ);
                cnt_q   <= CW'(HOLD_CYCLES - 1);
                state_q <= ARB_HOLD;
            end
        end else if (preempt) begin
            disp_q  <= sel_data;
            owner_q <= '0;
            rr_q    <= OW'(1);
            cnt_q   <= CW'(HOLD_CYCLES - 1);
        end else begin
            // Owner updates refresh the display but never extend the hold.
            if (xfer) begin
                disp_q <= sel_data;
            end
            if (cnt_q == '0) begin
                state_q <= ARB_IDLE;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign disp_out    = disp_q;
    assign owner_id    = owner_q;
    assign owner_valid = (state_q == ARB_HOLD);

endmodule
